// File: rtl/lc3_pc_pkg.sv
// Shared LC-3 program-counter definitions: next-PC source encodings used by
// the control FSM and the default address width / user-space start vector.
package lc3_pc_pkg;

    localparam int          LC3_ADDR_W     = 16;
    localparam logic [15:0] LC3_USER_START = 16'h3000;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_BUS = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;
    localparam logic [1:0] PC_SRC_RAS = 2'b11;

endpackage : lc3_pc_pkg

// File: rtl/lc3_ras.sv
// Return-address stack as a circular buffer with a top pointer; on overflow the
// oldest entry is overwritten so pops still return the most recent DEPTH pushes.
module lc3_ras #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf_evt,
    output logic             unf_evt
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, wr_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign top   = mem_q[ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_ptr  = ptr_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (push && pop) begin
            // Replace the top in place; an empty stack gains its first entry.
            wr_en = 1'b1;
            if (empty) begin
                unf_evt = 1'b1;
                count_d = CW'(1);
            end
        end else if (push) begin
            ptr_d  = ptr_q + 1'b1;
            wr_ptr = ptr_q + 1'b1;
            wr_en  = 1'b1;
            if (full) ovf_evt = 1'b1;
            else      count_d = count_q + 1'b1;
        end else if (pop) begin
            if (empty) begin
                unf_evt = 1'b1;
            end else begin
                ptr_d   = ptr_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the buffer is not reset; entries beyond count are never observed, so reset would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= din;
    end

endmodule : lc3_ras

// File: rtl/lc3_pc_unit.sv
// LC-3 program counter: gated PC register, next-PC mux, return-address stack
// qualification and sticky overflow/underflow flags.
module lc3_pc_unit
    import lc3_pc_pkg::*;
#(
    parameter int               WIDTH     = LC3_ADDR_W,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(LC3_USER_START),
    parameter int               RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_pc,
    input  logic [1:0]                   pc_mux,
    input  logic [WIDTH-1:0]             cpu_bus,
    input  logic [WIDTH-1:0]             jmp_addr,
    input  logic                         push,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             o_pc,
    output logic [WIDTH-1:0]             o_pc_inc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    logic [WIDTH-1:0] pc_q, pc_d, ras_top;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             ras_push, ras_pop, ovf_evt, unf_evt;

    assign ras_push = ld_pc && push;
    assign ras_pop  = ld_pc && (pc_mux == PC_SRC_RAS);
    assign o_pc_inc = pc_q + 1'b1;

    lc3_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (ras_push),
        .pop     (ras_pop),
        .din     (o_pc_inc),
        .top     (ras_top),
        .count   (ras_count),
        .empty   (ras_empty),
        .full    (ras_full),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    always_comb begin
        pc_d = pc_q;
        if (ld_pc) begin
            unique case (pc_mux)
                PC_SRC_INC: pc_d = o_pc_inc;
                PC_SRC_BUS: pc_d = cpu_bus;
                PC_SRC_JMP: pc_d = jmp_addr;
                PC_SRC_RAS: pc_d = ras_empty ? pc_q : ras_top;
            endcase
        end
        // A new error event wins over a same-cycle clear.
        ovf_d = ovf_evt || (ovf_q && !clr_err);
        unf_d = unf_evt || (unf_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign o_pc    = pc_q;
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

endmodule : lc3_pc_unit

// File: tb/tb_lc3_pc_unit.sv
// Self-checking bench for lc3_pc_unit: directed plan steps followed by random
// traffic, all compared against a queue-based reference model.
module tb_lc3_pc_unit;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RVEC  = 16'h3000;

    logic        clk = 1'b0;
    logic        rst, ld_pc, push, clr_err;
    logic [1:0]  pc_mux;
    logic [15:0] cpu_bus, jmp_addr;
    logic [15:0] o_pc, o_pc_inc;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_stack [$];
    logic        m_ovf, m_unf;

    always #5 clk = ~clk;

    lc3_pc_unit #(
        .WIDTH     (16),
        .RESET_VEC (RVEC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_pc     (ld_pc),
        .pc_mux    (pc_mux),
        .cpu_bus   (cpu_bus),
        .jmp_addr  (jmp_addr),
        .push      (push),
        .clr_err   (clr_err),
        .o_pc      (o_pc),
        .o_pc_inc  (o_pc_inc),
        .ras_count (ras_count),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model applies the architectural rules to the inputs present before the edge.
    task automatic model_update();
        logic [15:0] ra;
        logic        ovf_set, unf_set;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (rst) begin
            m_pc = RVEC;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        if (ld_pc) begin
            ra = m_pc + 16'd1;
            case (pc_mux)
                2'd0: m_pc = ra;
                2'd1: m_pc = cpu_bus;
                2'd2: m_pc = jmp_addr;
                default: begin
                    if (m_stack.size() == 0) begin
                        unf_set = 1'b1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                    if (push) m_stack.push_back(ra);
                end
            endcase
            if (push && pc_mux != 2'd3) begin
                m_stack.push_back(ra);
                if (m_stack.size() > DEPTH) begin
                    void'(m_stack.pop_front());
                    ovf_set = 1'b1;
                end
            end
        end
        m_ovf = ovf_set || (m_ovf && !clr_err);
        m_unf = unf_set || (m_unf && !clr_err);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    32'(o_pc),      32'(m_pc));
        check({tag, ".inc"},   32'(o_pc_inc),  32'(16'(m_pc + 16'd1)));
        check({tag, ".count"}, 32'(ras_count), 32'(m_stack.size()));
        check({tag, ".empty"}, 32'(ras_empty), 32'(m_stack.size() == 0));
        check({tag, ".full"},  32'(ras_full),  32'(m_stack.size() == DEPTH));
        check({tag, ".ovf"},   32'(ras_ovf),   32'(m_ovf));
        check({tag, ".unf"},   32'(ras_unf),   32'(m_unf));
    endtask

    task automatic step(input string tag, input logic r, input logic l, input logic [1:0] m,
                        input logic [15:0] bus, input logic [15:0] jmp,
                        input logic p, input logic c);
        rst      = r;
        ld_pc    = l;
        pc_mux   = m;
        cpu_bus  = bus;
        jmp_addr = jmp;
        push     = p;
        clr_err  = c;
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; ld_pc = 1'b0; pc_mux = 2'd0; cpu_bus = '0;
        jmp_addr = '0; push = 1'b0; clr_err = 1'b0;
        m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
        #1;

        // 1: reset and sequential fetch.
        step("rst", 1, 0, 0, 16'h0, 16'h0, 0, 0);
        check("rst.vec", 32'(o_pc), 32'h3000);
        for (int i = 0; i < 3; i++) step("inc", 0, 1, 0, 16'h0, 16'h0, 0, 0);
        check("inc.3003", 32'(o_pc), 32'h3003);

        // 2: wrap and ld_pc gating.
        step("bus_ffff", 0, 1, 1, 16'hFFFF, 16'h0, 0, 0);
        step("wrap", 0, 1, 0, 16'h0, 16'h0, 0, 0);
        check("wrap.0", 32'(o_pc), 32'h0000);
        step("gated", 0, 0, 1, 16'h1234, 16'h0, 1, 0);
        check("gated.hold", 32'(o_pc), 32'h0000);

        // 3: call and return.
        step("bus_3010", 0, 1, 1, 16'h3010, 16'h0, 0, 0);
        step("call", 0, 1, 2, 16'h0, 16'h4000, 1, 0);
        check("call.cnt", 32'(ras_count), 32'd1);
        step("ret", 0, 1, 3, 16'h0, 16'h0, 0, 0);
        check("ret.3011", 32'(o_pc), 32'h3011);

        // 4: overflow, drain in reverse order, then underflow.
        for (int i = 0; i < 5; i++) step("ovf_push", 0, 1, 2, 16'h0, 16'(16'h0100 * (i + 1)), 1, 0);
        check("ovf.flag", 32'(ras_ovf), 32'd1);
        for (int i = 0; i < 4; i++) step("ovf_pop", 0, 1, 3, 16'h0, 16'h0, 0, 0);
        check("ovf.last_pop", 32'(o_pc), 32'h0101);
        step("unf_pop", 0, 1, 3, 16'h0, 16'h0, 0, 0);
        check("unf.hold", 32'(o_pc), 32'h0101);

        // 5: simultaneous push and pop.
        step("rst5", 1, 0, 0, 16'h0, 16'h0, 0, 0);
        step("bus_1000", 0, 1, 1, 16'h1000, 16'h0, 0, 0);
        step("p1", 0, 1, 2, 16'h0, 16'h4FFF, 1, 0);
        step("p2", 0, 1, 2, 16'h0, 16'h5FFF, 1, 0);
        step("bus_6000", 0, 1, 1, 16'h6000, 16'h0, 0, 0);
        step("swap", 0, 1, 3, 16'h0, 16'h0, 1, 0);
        check("swap.5000", 32'(o_pc), 32'h5000);
        step("swap_pop", 0, 1, 3, 16'h0, 16'h0, 0, 0);
        check("swap.6001", 32'(o_pc), 32'h6001);
        step("empty_swap", 0, 1, 3, 16'h0, 16'h0, 0, 0);
        step("empty_swap2", 0, 1, 3, 16'h0, 16'h0, 1, 0);

        // 6: reset mid-operation, then clear racing an underflow.
        for (int i = 0; i < 5; i++) step("fill", 0, 1, 2, 16'h0, 16'(16'h2000 + i), 1, 0);
        step("fill_pop", 0, 1, 3, 16'h0, 16'h0, 0, 0);
        step("rst_mid", 1, 1, 1, 16'hBEEF, 16'h0, 1, 0);
        check("rst_mid.pc", 32'(o_pc), 32'h3000);
        step("clr_vs_unf", 0, 1, 3, 16'h0, 16'h0, 0, 1);
        check("clr_vs_unf.unf", 32'(ras_unf), 32'd1);
        step("clr_only", 0, 0, 3, 16'h0, 16'h0, 1, 1);
        check("clr_only.unf", 32'(ras_unf), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 16'($urandom),
                 16'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_lc3_pc_unit

// File: doc/lc3_pc_unit.md
Name: lc3_pc_unit

Overview:
Parametrised program-counter unit for the LC-3 datapath, successor to the fixed 16-bit PC.
- Adds real `ld_pc` gating, a programmable reset vector, and a hardware return-address stack (RAS) for JSR/JSRR/RET.
- Sits between the CPU bus, the address adder (branch/JMP targets) and the control FSM, which drives `pc_mux`, `ld_pc` and `push`.

Parameters:
- WIDTH, 16, PC/address width in bits (>=4).
- RESET_VEC, 16'h3000, PC value after reset (WIDTH bits, zero-extended/truncated).
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_pc  in  1  PC load enable; no PC or RAS state changes when 0.
- pc_mux  in  2  next-PC source: 00 pc+1, 01 cpu_bus, 10 jmp_addr, 11 RAS pop.
- cpu_bus  in  WIDTH  value from CPU bus.
- jmp_addr  in  WIDTH  target from address adder.
- push  in  1  push return address (pc+1) onto RAS; effective only with ld_pc=1.
- clr_err  in  1  clears sticky `ras_ovf` and `ras_unf`.
- o_pc  out  WIDTH  current PC.
- o_pc_inc  out  WIDTH  combinational pc+1, modulo 2^WIDTH.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  out  1  ras_count==0.
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_ovf  out  1  sticky: push occurred while full.
- ras_unf  out  1  sticky: pop occurred while empty.

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_VEC; ras_count<=0; ras_ovf<=0; ras_unf<=0. RAS contents are don't-care. Reset overrides every other input on the same edge.
- Latency: 1 cycle. A value selected at edge N is visible on `o_pc` after edge N. No combinational path from inputs to `o_pc`.
- ld_pc=0: pc, RAS, count and flags hold. `push` and `pc_mux` are ignored. `clr_err` still acts.
- ld_pc=1, next pc by pc_mux:
  - 00: pc+1, wrapping all-ones -> 0.
  - 01: cpu_bus.
  - 10: jmp_addr.
  - 11: pop. Non-empty: pc<=top entry, count-1. Empty: pc holds, ras_unf<=1, count stays 0.
- Push (ld_pc=1, push=1, pc_mux!=11): writes o_pc_inc (return address of the current instruction) as the new top.
  - Not full: count+1.
  - Full: circular overwrite of the oldest entry, count stays RAS_DEPTH, ras_ovf<=1.
- Simultaneous push and pop (pc_mux=11, push=1): pc<=old top and the top entry is replaced by o_pc_inc; count unchanged.
  - If empty: pc holds, ras_unf<=1, the entry is written and count<=1.
- Stack is LIFO, implemented as a circular buffer with a top pointer modulo RAS_DEPTH. Pop after overflow returns the most recent RAS_DEPTH pushes in reverse order.
- Sticky flags: set has priority over clr_err on the same edge.
- Combinational outputs: ras_empty and ras_full derive from ras_count.
- Illegal combinations: none. Every input pattern has defined behaviour.

Decomposition:
- Package lc3_pc_pkg:
  - localparams PC_SRC_INC=2'b00, PC_SRC_BUS=2'b01, PC_SRC_JMP=2'b10, PC_SRC_RAS=2'b11, shared with the control FSM.
  - Default LC3_ADDR_W=16 and LC3_USER_START=16'h3000.
- Sub-module lc3_ras (parameters WIDTH, DEPTH):
  - Inputs push, pop, din. Outputs top, count, empty, full, ovf_evt, unf_evt.
  - Owns the circular buffer and the pointer.
- lc3_pc_unit owns: pc register, next-PC mux, push/pop qualification with ld_pc, sticky flags.

Test Plan:
1. Reset then 3 cycles ld_pc=1, pc_mux=00 -> o_pc 3000, 3001, 3002, 3003; ras_empty=1, flags 0.
2. Wrap and gating: load cpu_bus=FFFF, then pc_mux=00 -> o_pc=0000. ld_pc=0 with pc_mux=01, cpu_bus=1234 -> o_pc stays 0000.
3. Call/return: at pc=3010, push=1, pc_mux=10, jmp_addr=4000 -> o_pc=4000, count=1. Then pc_mux=11 -> o_pc=3011, count=0, ras_empty=1.
4. Overflow: 5 pushes with return addresses A1..A5 (depth 4) -> ras_full=1, ras_ovf=1 after the 5th. Then 4 pops -> A5, A4, A3, A2. A 5th pop -> pc holds, ras_unf=1.
5. Simultaneous: count=2, top=5000, pc=6000, push=1, pc_mux=11 -> o_pc=5000, count=2. Next pop -> o_pc=6001.
6. Reset mid-operation: count=3, ras_ovf=1, rst=1 with ld_pc=1, pc_mux=01 -> o_pc=3000, count=0, flags 0. clr_err concurrent with an underflow -> ras_unf=1.
